// File: rtl/mips_enc_pkg.sv
// Shared MIPS encoding constants: op selector, opcodes, funct codes and
// small packing helpers, common to the encoder and the control-unit decode.
package mips_enc_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_LW   = 4'd5,
    OP_SW   = 4'd6,
    OP_BEQ  = 4'd7,
    OP_ADDI = 4'd8,
    OP_J    = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FULL  = 2'd2
  } enc_state_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // R-type word; shamt is always zero for the supported ops.
  function automatic logic [31:0] packR(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OPC_RTYPE, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] packI(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] packJ(input logic [25:0] target);
    return {OPC_J, target};
  endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Op-in / word-out streaming bus of the instruction encoder.
// master = op producer and memory side, slave = encoder.
interface mips_instr_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
    input  in_ready, out_valid, out_word, out_addr
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
    output in_ready, out_valid, out_word, out_addr
  );
endinterface

// File: rtl/mips_field_pack.sv
// Combinational op + fields -> 32-bit instruction word and legality flag.
module mips_field_pack
  import mips_enc_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_legal
);

  // Select the instruction format for the op; unused fields are simply not packed.
  always_comb begin
    o_word  = 32'h0;
    o_legal = 1'b1;
    case (op_e'(i_op))
      OP_ADD:  o_word = packR(i_rs, i_rt, i_rd, FN_ADD);
      OP_SUB:  o_word = packR(i_rs, i_rt, i_rd, FN_SUB);
      OP_AND:  o_word = packR(i_rs, i_rt, i_rd, FN_AND);
      OP_OR:   o_word = packR(i_rs, i_rt, i_rd, FN_OR);
      OP_SLT:  o_word = packR(i_rs, i_rt, i_rd, FN_SLT);
      OP_LW:   o_word = packI(OPC_LW, i_rs, i_rt, i_imm);
      OP_SW:   o_word = packI(OPC_SW, i_rs, i_rt, i_imm);
      OP_BEQ:  o_word = packI(OPC_BEQ, i_rs, i_rt, i_imm);
      OP_ADDI: o_word = packI(OPC_ADDI, i_rs, i_rt, i_imm);
      OP_J:    o_word = packJ(i_target);
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: encodes symbolic MIPS ops into instruction words and
// streams them with sequential word addresses into instruction memory.
// One output register stage, sticky illegal-op flag, stops after DEPTH words.
module mips_instr_encoder
  import mips_enc_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  mips_instr_encoder_if.slave bus,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);

  enc_state_e        r_state;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_err;

  logic [31:0] w_word;
  logic        w_legal;
  logic        w_outValid;
  logic        w_inReady;
  logic        w_accept;
  logic        w_acceptLegal;
  logic        w_drain;
  logic        w_fullNext;

  mips_field_pack u_pack (
    .i_op     (bus.in_op),
    .i_rs     (bus.in_rs),
    .i_rt     (bus.in_rt),
    .i_rd     (bus.in_rd),
    .i_imm    (bus.in_imm),
    .i_target (bus.in_target),
    .o_word   (w_word),
    .o_legal  (w_legal)
  );

  // A new op may enter when the output slot is free or being drained this
  // cycle; clr blocks acceptance so a restart never races with a new word.
  assign w_outValid    = (r_state == ST_HOLD);
  assign w_inReady     = !r_full && (!w_outValid || bus.out_ready) && !clr;
  assign w_accept      = bus.in_valid && w_inReady;
  assign w_acceptLegal = w_accept && w_legal;
  assign w_drain       = w_outValid && bus.out_ready;
  assign w_fullNext    = clr ? 1'b0 : (w_acceptLegal ? (r_count == LAST_COUNT) : r_full);

  // Holding FSM plus output word register, address counter and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_word  <= 32'h0;
      r_addr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_acceptLegal) r_state <= ST_HOLD;
        ST_HOLD:  if (!w_acceptLegal && w_drain) r_state <= w_fullNext ? ST_FULL : ST_EMPTY;
        ST_FULL:  if (clr) r_state <= ST_EMPTY;
        default:  r_state <= ST_EMPTY;
      endcase

      if (w_acceptLegal) begin
        r_word <= w_word;
        r_addr <= r_count[ADDR_W-1:0];
      end

      if (clr) begin
        r_count <= '0;
      end else if (w_acceptLegal) begin
        r_count <= r_count + 1'b1;
      end

      r_full <= w_fullNext;

      if (w_accept && !w_legal) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.out_word  = r_word;
  assign bus.out_addr  = r_addr;
  assign count         = r_count;
  assign full          = r_full;
  assign err           = r_err;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for the MIPS instruction encoder: directed op sequences, a
// transaction-level model checked every cycle, literal spot checks.
module tb_mips_instr_encoder;
  import mips_enc_pkg::*;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            clr;
  logic [ADDR_W:0] count;
  logic            full;
  logic            err;

  mips_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  mips_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .bus   (bus),
    .count (count),
    .full  (full),
    .err   (err)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;
  longint cycle = 0;

  // Model of what the loader must hold: at most one pending word, a word
  // count, and the two flags.
  bit          armed = 1'b0;
  bit          mValid = 1'b0;
  logic [31:0] mWord = 32'h0;
  int          mAddr = 0;
  int          mCount = 0;
  bit          mFull = 1'b0;
  bit          mErr = 1'b0;

  logic [31:0] drainWords[$];
  int          drainAddrs[$];
  longint      drainCycles[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Instruction word computed arithmetically from the MIPS field positions.
  function automatic logic [31:0] modelEncode(input longint op, input longint rs, input longint rt,
                                              input longint rd, input longint imm, input longint tgt);
    longint functs[5];
    longint opcs[4];
    longint w;
    functs = '{32, 34, 36, 37, 42};
    opcs   = '{35, 43, 4, 8};
    if (op <= 4)      w = rs * (2 ** 21) + rt * (2 ** 16) + rd * (2 ** 11) + functs[op];
    else if (op <= 8) w = opcs[op - 5] * (2 ** 26) + rs * (2 ** 21) + rt * (2 ** 16) + imm;
    else              w = 2 * (2 ** 26) + tgt;
    return 32'(w);
  endfunction

  always @(posedge clk) cycle <= cycle + 1;

  // Advance the model on each clock from the inputs the bench presents.
  always @(posedge clk) begin : modelStep
    bit acc;
    bit nValid;
    int nCount;
    bit nFull;
    bit nErr;
    if (rst) begin
      armed  <= 1'b1;
      mValid <= 1'b0;
      mWord  <= 32'h0;
      mAddr  <= 0;
      mCount <= 0;
      mFull  <= 1'b0;
      mErr   <= 1'b0;
    end else if (armed) begin
      acc    = bus.in_valid && !mFull && (!mValid || bus.out_ready) && !clr;
      nValid = mValid && !bus.out_ready;
      nCount = mCount;
      nFull  = mFull;
      nErr   = mErr;
      if (acc) begin
        if (bus.in_op > 4'd9) begin
          nErr = 1'b1;
        end else begin
          mWord  <= modelEncode(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm, bus.in_target);
          mAddr  <= mCount % (1 << ADDR_W);
          nValid = 1'b1;
          nCount = mCount + 1;
          if (nCount == DEPTH) nFull = 1'b1;
        end
      end
      if (clr) begin
        nCount = 0;
        nFull  = 1'b0;
      end
      mValid <= nValid;
      mCount <= nCount;
      mFull  <= nFull;
      mErr   <= nErr;
    end
  end

  // Record every word the memory side consumes.
  always @(posedge clk) begin
    if (armed && !rst && bus.out_valid === 1'b1 && bus.out_ready) begin
      drainWords.push_back(bus.out_word);
      drainAddrs.push_back(int'(bus.out_addr));
      drainCycles.push_back(cycle);
    end
  end

  // Compare DUT against the model in the middle of every cycle.
  always @(negedge clk) begin
    if (armed) begin
      checkOutput("out_valid", 32'(bus.out_valid), 32'(mValid));
      if (mValid) begin
        checkOutput("out_word", bus.out_word, mWord);
        checkOutput("out_addr", 32'(bus.out_addr), 32'(mAddr));
      end
      checkOutput("in_ready", 32'(bus.in_ready), 32'(!mFull && (!mValid || bus.out_ready) && !clr));
      checkOutput("count", 32'(count), 32'(mCount));
      checkOutput("full", 32'(full), 32'(mFull));
      checkOutput("err", 32'(err), 32'(mErr));
    end
  end

  task automatic setOp(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    bus.in_op     = op;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_rd     = rd;
    bus.in_imm    = imm;
    bus.in_target = tgt;
    bus.in_valid  = 1'b1;
  endtask

  // Hold the presented op until the encoder takes it, within a cycle budget.
  task automatic waitAccept(input string name);
    bit acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    checkOutput({name, " accepted"}, 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input string name, input logic [3:0] op, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                               input logic [25:0] tgt);
    setOp(op, rs, rt, rd, imm, tgt);
    waitAccept(name);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseClr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic pulseRst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clearDrained();
    drainWords.delete();
    drainAddrs.delete();
    drainCycles.delete();
  endtask

  initial begin
    logic [31:0] expW[4];
    rst = 1'b1;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = 4'd0;
    bus.in_rs = 5'd0;
    bus.in_rt = 5'd0;
    bus.in_rd = 5'd0;
    bus.in_imm = 16'd0;
    bus.in_target = 26'd0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst out_word", bus.out_word, 32'h0);
    checkOutput("rst out_addr", 32'(bus.out_addr), 32'd0);
    checkOutput("rst count", 32'(count), 32'd0);
    checkOutput("rst full", 32'(full), 32'd0);
    checkOutput("rst err", 32'(err), 32'd0);
    checkOutput("rst in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single ADD, one cycle accept -> out_valid
    applyStimulus("add", OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    @(negedge clk);
    checkOutput("add out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("add out_word", bus.out_word, 32'h00221820);
    checkOutput("add out_addr", 32'(bus.out_addr), 32'd0);
    checkOutput("add count", 32'(count), 32'd1);
    idle(2);
    pulseClr();

    // Back-to-back stream filling DEPTH, then two refused ops
    clearDrained();
    applyStimulus("lw", OP_LW, 5'd9, 5'd8, 5'd0, 16'h0004, 26'h0);
    applyStimulus("beq", OP_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
    applyStimulus("addi", OP_ADDI, 5'd0, 5'd5, 5'd0, 16'h0007, 26'h0);
    applyStimulus("j", OP_J, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
    @(negedge clk);
    checkOutput("depth full", 32'(full), 32'd1);
    checkOutput("depth in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("depth count", 32'(count), 32'd4);
    setOp(OP_ADD, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("full refuses", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    idle(2);
    expW = '{32'h8D280004, 32'h1022FFFF, 32'h20050007, 32'h08000010};
    checkOutput("stream n", 32'(drainWords.size()), 32'd4);
    for (int i = 0; i < 4 && i < drainWords.size(); i++) begin
      checkOutput($sformatf("stream word%0d", i), drainWords[i], expW[i]);
      checkOutput($sformatf("stream addr%0d", i), 32'(drainAddrs[i]), 32'(i));
      checkOutput($sformatf("stream gap%0d", i), 32'(drainCycles[i] - drainCycles[0]), 32'(i));
    end
    pulseClr();
    applyStimulus("after clr", OP_ADDI, 5'd0, 5'd5, 5'd0, 16'h0007, 26'h0);
    @(negedge clk);
    checkOutput("clr addr", 32'(bus.out_addr), 32'd0);
    checkOutput("clr count", 32'(count), 32'd1);
    idle(2);
    pulseRst();

    // Back-pressure: output stalled for 5 cycles with an op waiting
    clearDrained();
    bus.out_ready = 1'b0;
    applyStimulus("stall add", OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    setOp(OP_SUB, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("stall word", bus.out_word, 32'h00221820);
      checkOutput("stall addr", 32'(bus.out_addr), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    waitAccept("stall sub");
    idle(2);
    checkOutput("stall n", 32'(drainWords.size()), 32'd2);
    if (drainWords.size() == 2) begin
      checkOutput("stall w0", drainWords[0], 32'h00221820);
      checkOutput("stall w1", drainWords[1], 32'h00853022);
      checkOutput("stall a1", 32'(drainAddrs[1]), 32'd1);
    end
    pulseRst();

    // Illegal op between two ADDs
    clearDrained();
    applyStimulus("ill add0", OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    applyStimulus("ill op12", 4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    applyStimulus("ill add1", OP_ADD, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0);
    idle(2);
    @(negedge clk);
    checkOutput("ill err", 32'(err), 32'd1);
    checkOutput("ill count", 32'(count), 32'd2);
    checkOutput("ill n", 32'(drainWords.size()), 32'd2);
    if (drainWords.size() == 2) begin
      checkOutput("ill a0", 32'(drainAddrs[0]), 32'd0);
      checkOutput("ill a1", 32'(drainAddrs[1]), 32'd1);
      checkOutput("ill w1", drainWords[1], 32'h00E84820);
    end
    @(posedge clk);
    #1;
    pulseClr();
    @(negedge clk);
    checkOutput("err sticky clr", 32'(err), 32'd1);
    @(posedge clk);
    #1;

    // Reset while a word is held and stalled
    bus.out_ready = 1'b0;
    applyStimulus("hold add", OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    pulseRst();
    @(negedge clk);
    checkOutput("rst hold out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst hold count", 32'(count), 32'd0);
    checkOutput("rst hold err", 32'(err), 32'd0);
    checkOutput("rst hold full", 32'(full), 32'd0);
    bus.out_ready = 1'b1;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
